// File: rtl/userio_joy_serial.sv
// Serial joystick scanner: loads an external 32-bit shift-register chain, clocks it out
// and publishes two 16-bit button words once per complete frame.
module userio_joy_serial #(
  parameter int CLK_DIV   = 16,
  parameter int GAP_TICKS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  div_reg, div_next;
  logic [9:0]  gap_reg, gap_next;
  logic [4:0]  bit_reg, bit_next;
  logic        phase_reg, phase_next;
  logic [1:0]  sync_reg;
  logic [31:0] shreg_reg, shreg_next;
  logic        joy_clk_reg, joy_clk_next;
  logic        joy_load_reg, joy_load_next;
  logic [15:0] joy1_reg, joy1_next;
  logic [15:0] joy2_reg, joy2_next;
  logic        done_reg, done_next;
  logic        tick;
  logic        sample;

  assign tick = (div_reg == 8'(CLK_DIV - 1));

  // Each bit is captured at the end of its low phase, stored inverted (chain is active low).
  for (genvar gi = 0; gi < 32; gi++) begin : g_capture
    assign shreg_next[gi] = (sample && (bit_reg == 5'(gi))) ? ~sync_reg[1] : shreg_reg[gi];
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = tick ? 8'd0 : div_reg + 8'd1;
    gap_next      = gap_reg;
    bit_next      = bit_reg;
    phase_next    = phase_reg;
    joy_clk_next  = joy_clk_reg;
    joy_load_next = joy_load_reg;
    joy1_next     = joy1_reg;
    joy2_next     = joy2_reg;
    done_next     = 1'b0;
    sample        = 1'b0;

    if (!enable) begin
      // Divider is held so a re-enable always sees a full GAP_TICKS gap of whole ticks.
      state_next    = ST_IDLE;
      div_next      = 8'd0;
      gap_next      = 10'd0;
      bit_next      = 5'd0;
      phase_next    = 1'b0;
      joy_clk_next  = 1'b1;
      joy_load_next = 1'b1;
      joy1_next     = 16'h0000;
      joy2_next     = 16'h0000;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          joy_clk_next  = 1'b1;
          joy_load_next = 1'b1;
          if (tick) begin
            if (gap_reg == 10'(GAP_TICKS - 1)) begin
              state_next    = ST_LOAD;
              gap_next      = 10'd0;
              phase_next    = 1'b0;
              joy_load_next = 1'b0;
            end else begin
              gap_next = gap_reg + 10'd1;
            end
          end
        end
        ST_LOAD: begin
          if (tick) begin
            if (!phase_reg) begin
              phase_next = 1'b1;
            end else begin
              state_next    = ST_SHIFT;
              phase_next    = 1'b0;
              bit_next      = 5'd0;
              joy_clk_next  = 1'b0;
              joy_load_next = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!phase_reg) begin
              sample       = 1'b1;
              phase_next   = 1'b1;
              joy_clk_next = 1'b1;
            end else if (bit_reg == 5'd31) begin
              state_next = ST_DONE;
              phase_next = 1'b0;
            end else begin
              bit_next     = bit_reg + 5'd1;
              phase_next   = 1'b0;
              joy_clk_next = 1'b0;
            end
          end
        end
        ST_DONE: begin
          joy1_next  = shreg_reg[15:0];
          joy2_next  = shreg_reg[31:16];
          done_next  = 1'b1;
          bit_next   = 5'd0;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      div_reg      <= 8'd0;
      gap_reg      <= 10'd0;
      bit_reg      <= 5'd0;
      phase_reg    <= 1'b0;
      sync_reg     <= 2'b11;
      shreg_reg    <= 32'd0;
      joy_clk_reg  <= 1'b1;
      joy_load_reg <= 1'b1;
      joy1_reg     <= 16'h0000;
      joy2_reg     <= 16'h0000;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      gap_reg      <= gap_next;
      bit_reg      <= bit_next;
      phase_reg    <= phase_next;
      sync_reg     <= {sync_reg[0], JOY_DATA};
      shreg_reg    <= shreg_next;
      joy_clk_reg  <= joy_clk_next;
      joy_load_reg <= joy_load_next;
      joy1_reg     <= joy1_next;
      joy2_reg     <= joy2_next;
      done_reg     <= done_next;
    end
  end

  assign JOY_CLK    = joy_clk_reg;
  assign JOY_LOAD   = joy_load_reg;
  assign joystick1  = joy1_reg;
  assign joystick2  = joy2_reg;
  assign frame_done = done_reg;

endmodule
